// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the RV32 data-memory responder and its array.
// Holds the FSM state encoding, bus widths and the byte-enable merge function.
package riscv_mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic [DATA_W-1:0] apply_be(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wdata,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/riscv_dmem_array.sv
// DEPTH x 32 data array: synchronous byte-enabled write, combinational read, no reset.
// Contents survive reset; the caller is responsible for range-checking the write index.
module riscv_dmem_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= apply_be(mem[wr_idx], wr_data, wr_be);
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/riscv_dmem_responder.sv
// Single-outstanding load/store responder; response valid WAIT_CYCLES+1 edges after accept.
// Response is held until rsp_ready; req_ready stays low from accept until the cycle after that handshake.
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;

    logic              accept, enter_resp, rsp_done;
    logic              in_range, wr_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    assign in_range  = 32'(lat_addr) < 32'(DEPTH);
    assign idx       = lat_addr[IDX_W-1:0];
    // A store aborted by reset on its commit edge must not reach the array.
    assign wr_en     = enter_resp & lat_we & in_range & ~rst;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    enter_resp = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Even with zero wait states the request spends one cycle in WAIT, so the
    // array is always addressed from the latched copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                cnt       <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_resp) begin
                rsp_err   <= ~in_range;
                rsp_rdata <= (!lat_we && in_range) ? rd_word : '0;
            end else if (rsp_done) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    riscv_dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (lat_wdata),
        .wr_be   (lat_be),
        .rd_idx  (idx),
        .rd_data (rd_word)
    );

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench: a 6-bit-address, 2-wait-state instance for the main sequence and
// a zero-wait-state instance with rsp_ready tied high for back-to-back throughput.
module tb_riscv_dmem_responder;

    logic        clk;
    logic        rst;

    logic        req_valid, req_ready, req_we;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [4:0]  b_req_addr;
    logic [31:0] b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_rsp_valid, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_dmem_responder #(.DEPTH(32), .ADDR_W(6), .WAIT_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    riscv_dmem_responder #(.DEPTH(32), .ADDR_W(5), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_we    (b_req_we),
        .req_addr  (b_req_addr),
        .req_wdata (b_req_wdata),
        .req_be    (b_req_be),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (1'b1),
        .rsp_rdata (b_rsp_rdata),
        .rsp_err   (b_rsp_err),
        .busy      (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check latency, optionally hold the response for `hold`
    // cycles checking stability, then complete the handshake.
    task automatic issue(input logic we, input logic [5:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int hold,
                         output logic [31:0] rd, output logic er);
        int lat;
        chk("pre_req_ready", {31'd0, req_ready}, 32'd1);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wd;
        req_be    = ~be;
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_req_ready", {31'd0, req_ready}, 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        rd = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("done_rdata", rsp_rdata, 32'd0);
        chk("done_err", {31'd0, rsp_err}, 32'd0);
        chk("done_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        issue(1'b1, 6'd3, 32'hDEADBEEF, 4'hF, 0, rd, er);
        chk("st3_rdata", rd, 32'd0);
        chk("st3_err", {31'd0, er}, 32'd0);

        issue(1'b0, 6'd3, 32'h0, 4'h0, 0, rd, er);
        chk("ld3_rdata", rd, 32'hDEADBEEF);
        chk("ld3_err", {31'd0, er}, 32'd0);

        issue(1'b1, 6'd3, 32'h000000AA, 4'h1, 0, rd, er);
        issue(1'b0, 6'd3, 32'h0, 4'h0, 0, rd, er);
        chk("ld3_be1", rd, 32'hDEADBEAA);

        issue(1'b1, 6'd3, 32'h12345678, 4'h0, 0, rd, er);
        chk("st_be0_err", {31'd0, er}, 32'd0);
        issue(1'b0, 6'd3, 32'h0, 4'h0, 0, rd, er);
        chk("ld3_after_be0", rd, 32'hDEADBEAA);

        issue(1'b1, 6'd8, 32'h08080808, 4'hF, 0, rd, er);
        issue(1'b0, 6'd40, 32'h0, 4'h0, 0, rd, er);
        chk("ld40_err", {31'd0, er}, 32'd1);
        chk("ld40_rdata", rd, 32'd0);
        issue(1'b1, 6'd40, 32'hFFFFFFFF, 4'hF, 0, rd, er);
        chk("st40_err", {31'd0, er}, 32'd1);
        issue(1'b0, 6'd8, 32'h0, 4'h0, 0, rd, er);
        chk("ld8_after_st40", rd, 32'h08080808);
        issue(1'b0, 6'd3, 32'h0, 4'h0, 0, rd, er);
        chk("ld3_after_st40", rd, 32'hDEADBEAA);

        issue(1'b0, 6'd3, 32'h0, 4'h0, 5, rd, er);
        chk("bp_rdata", rd, 32'hDEADBEAA);

        issue(1'b1, 6'd7, 32'h11111111, 4'hF, 0, rd, er);
        req_we = 1'b1; req_addr = 6'd7; req_wdata = 32'h22222222; req_be = 4'hF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_rdata", rsp_rdata, 32'd0);
        repeat (4) tick();
        chk("abort_quiet", {31'd0, rsp_valid}, 32'd0);
        issue(1'b0, 6'd7, 32'h0, 4'h0, 0, rd, er);
        chk("ld7_after_abort", rd, 32'h11111111);

        // Zero-wait instance: store then back-to-back loads with req_valid held high.
        b_req_we = 1'b1; b_req_addr = 5'd5; b_req_wdata = 32'hCAFEF00D; b_req_be = 4'hF;
        b_req_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) b_req_we = 1'b0;
            chk("b2b_rsp_valid", {31'd0, b_rsp_valid}, {31'd0, (k % 3) == 2});
            chk("b2b_req_ready", {31'd0, b_req_ready}, {31'd0, (k % 3) == 0});
            chk("b2b_busy", {31'd0, b_busy}, {31'd0, (k % 3) != 0});
            if ((k % 3) == 2) begin
                chk("b2b_rdata", b_rsp_rdata, (k == 2) ? 32'd0 : 32'hCAFEF00D);
                chk("b2b_err", {31'd0, b_rsp_err}, 32'd0);
            end
        end
        b_req_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
